// File: rtl/led_blinker.sv
// led_blinker: four free-running tone toggles (c100/c50/c10/c1 half-periods), switch-selected, enable-gated onto o_led_drive
module led_blinker #(
  parameter int unsigned c100 = 125000,
  parameter int unsigned c50  = 250000,
  parameter int unsigned c10  = 1250000,
  parameter int unsigned c1   = 12500000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_switch_1,
  input  logic i_switch_2,
  output logic o_led_drive,
  output logic dbg_t100,
  output logic dbg_t50,
  output logic dbg_t10,
  output logic dbg_t1,
  output logic dbg_temp_o_led
);
  localparam logic [31:0] half [4] = '{c100, c50, c10, c1};
  logic [3:0] t;
  for (genvar i = 0; i < 4; i++) begin : g_tone
    logic [31:0] cnt;
    logic tog;
    always_ff @(posedge i_clock)
      if (i_reset) begin
        cnt <= '0;
        tog <= 1'b0;
      end else if (cnt == half[i] - 32'd1) begin
        cnt <= '0;
        tog <= ~tog;
      end else begin
        cnt <= cnt + 32'd1;
      end
    assign t[i] = tog;
  end
  assign {dbg_t1, dbg_t10, dbg_t50, dbg_t100} = t;
  assign dbg_temp_o_led = t[{i_switch_1, i_switch_2}];
  assign o_led_drive = dbg_temp_o_led & i_enable;
endmodule

// File: tb/tb_led_blinker.sv
// tb_led_blinker: directed self-checking bench for led_blinker with c100=10, c50=20, c10=50, c1=100
module tb_led_blinker;
  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  logic i_enable = 1'b0;
  logic i_switch_1 = 1'b0;
  logic i_switch_2 = 1'b0;
  logic o_led_drive, dbg_t100, dbg_t50, dbg_t10, dbg_t1, dbg_temp_o_led;
  int errors = 0;
  int checks = 0;
  int k = 0;
  led_blinker #(.c100(10), .c50(20), .c10(50), .c1(100)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_enable(i_enable),
    .i_switch_1(i_switch_1),
    .i_switch_2(i_switch_2),
    .o_led_drive(o_led_drive),
    .dbg_t100(dbg_t100),
    .dbg_t50(dbg_t50),
    .dbg_t10(dbg_t10),
    .dbg_t1(dbg_t1),
    .dbg_temp_o_led(dbg_temp_o_led)
  );
  always #5 i_clock = ~i_clock;
  function automatic logic ex(int c);
    return ((k / c) % 2) == 1;
  endfunction
  function automatic int csel(int s);
    return s == 0 ? 10 : s == 1 ? 20 : s == 2 ? 50 : 100;
  endfunction
  function automatic logic [3:0] tones_ex();
    return {ex(100), ex(50), ex(20), ex(10)};
  endfunction
  task automatic step();
    @(posedge i_clock);
    k = i_reset ? 0 : k + 1;
    #1;
  endtask
  task automatic set_sw(input logic [1:0] s);
    {i_switch_1, i_switch_2} = s;
    #1;
  endtask
  task automatic test_reset();
    i_reset = 1'b1;
    i_enable = 1'b1;
    set_sw(2'b00);
    step();
    step();
    checks++;
    if ({dbg_t1, dbg_t10, dbg_t50, dbg_t100} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_tones got=%b want=0000", {dbg_t1, dbg_t10, dbg_t50, dbg_t100});
    end
    checks++;
    if (o_led_drive !== 1'b0) begin
      errors++;
      $display("FAIL reset_led got=%b want=0", o_led_drive);
    end
    checks++;
    if (dbg_temp_o_led !== 1'b0) begin
      errors++;
      $display("FAIL reset_temp got=%b want=0", dbg_temp_o_led);
    end
  endtask
  task automatic test_t100();
    i_reset = 1'b0;
    for (int n = 0; n < 45; n++) begin
      step();
      checks++;
      if ({dbg_t1, dbg_t10, dbg_t50, dbg_t100} !== tones_ex()) begin
        errors++;
        $display("FAIL t100_tones k=%0d got=%b want=%b", k, {dbg_t1, dbg_t10, dbg_t50, dbg_t100}, tones_ex());
      end
      checks++;
      if (o_led_drive !== ex(10)) begin
        errors++;
        $display("FAIL t100_led k=%0d got=%b want=%b", k, o_led_drive, ex(10));
      end
    end
  endtask
  task automatic test_sweep();
    i_enable = 1'b1;
    for (int s = 1; s < 4; s++) begin
      set_sw(2'(s));
      checks++;
      if (dbg_temp_o_led !== ex(csel(s))) begin
        errors++;
        $display("FAIL sweep_select sw=%0d k=%0d got=%b want=%b", s, k, dbg_temp_o_led, ex(csel(s)));
      end
      for (int n = 0; n < 200; n++) begin
        step();
        checks++;
        if (dbg_temp_o_led !== ex(csel(s)) || o_led_drive !== ex(csel(s))) begin
          errors++;
          $display("FAIL sweep sw=%0d k=%0d temp=%b led=%b want=%b", s, k, dbg_temp_o_led, o_led_drive, ex(csel(s)));
        end
      end
    end
  endtask
  task automatic test_enable_off();
    i_enable = 1'b0;
    for (int s = 0; s < 4; s++) begin
      set_sw(2'(s));
      for (int n = 0; n < 30; n++) begin
        step();
        checks++;
        if (o_led_drive !== 1'b0) begin
          errors++;
          $display("FAIL enable_off_led sw=%0d k=%0d got=%b want=0", s, k, o_led_drive);
        end
        checks++;
        if (dbg_temp_o_led !== ex(csel(s)) || {dbg_t1, dbg_t10, dbg_t50, dbg_t100} !== tones_ex()) begin
          errors++;
          $display("FAIL enable_off_tones sw=%0d k=%0d temp=%b tones=%b want temp=%b tones=%b", s, k, dbg_temp_o_led, {dbg_t1, dbg_t10, dbg_t50, dbg_t100}, ex(csel(s)), tones_ex());
        end
      end
    end
    i_enable = 1'b1;
  endtask
  task automatic test_switch_change();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    set_sw(2'b00);
    repeat (35) step();
    checks++;
    if (o_led_drive !== 1'b1) begin
      errors++;
      $display("FAIL switch_pre k=%0d got=%b want=1", k, o_led_drive);
    end
    set_sw(2'b11);
    checks++;
    if (dbg_temp_o_led !== 1'b0 || o_led_drive !== 1'b0) begin
      errors++;
      $display("FAIL switch_to_t1 k=%0d temp=%b led=%b want=0", k, dbg_temp_o_led, o_led_drive);
    end
    repeat (22) step();
    checks++;
    if (dbg_temp_o_led !== ex(100)) begin
      errors++;
      $display("FAIL switch_hold_t1 k=%0d got=%b want=%b", k, dbg_temp_o_led, ex(100));
    end
    set_sw(2'b00);
    checks++;
    if (dbg_temp_o_led !== 1'b1 || {dbg_t1, dbg_t10, dbg_t50, dbg_t100} !== tones_ex()) begin
      errors++;
      $display("FAIL switch_back_t100 k=%0d temp=%b tones=%b want temp=1 tones=%b", k, dbg_temp_o_led, {dbg_t1, dbg_t10, dbg_t50, dbg_t100}, tones_ex());
    end
  endtask
  task automatic test_reset_pulse();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    set_sw(2'b00);
    repeat (15) step();
    checks++;
    if (dbg_t100 !== 1'b1) begin
      errors++;
      $display("FAIL pulse_pre k=%0d got=%b want=1", k, dbg_t100);
    end
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    checks++;
    if ({dbg_t1, dbg_t10, dbg_t50, dbg_t100, o_led_drive} !== 5'b00000) begin
      errors++;
      $display("FAIL pulse_clear got=%b want=00000", {dbg_t1, dbg_t10, dbg_t50, dbg_t100, o_led_drive});
    end
    for (int n = 0; n < 25; n++) begin
      step();
      checks++;
      if ({dbg_t1, dbg_t10, dbg_t50, dbg_t100} !== tones_ex() || o_led_drive !== ex(10)) begin
        errors++;
        $display("FAIL pulse_after k=%0d tones=%b led=%b want tones=%b led=%b", k, {dbg_t1, dbg_t10, dbg_t50, dbg_t100}, o_led_drive, tones_ex(), ex(10));
      end
    end
  endtask
  initial begin
    test_reset();
    test_t100();
    test_sweep();
    test_enable_off();
    test_switch_change();
    test_reset_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_blinker.md
LED_BLINKER -- requirements
Module: led_blinker

Interface
REQ-001 Parameter c100, default 125000: half-period of the 100 Hz tone, in i_clock cycles (25 MHz clock).
REQ-002 Parameter c50, default 250000: half-period of the 50 Hz tone, in cycles.
REQ-003 Parameter c10, default 1250000: half-period of the 10 Hz tone, in cycles.
REQ-004 Parameter c1, default 12500000: half-period of the 1 Hz tone, in cycles.
REQ-005 i_clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_enable  input  1  output gate; 1 = LED drive follows the selected tone.
REQ-008 i_switch_1  input  1  frequency select, MSB.
REQ-009 i_switch_2  input  1  frequency select, LSB.
REQ-010 o_led_drive  output  1  gated LED drive.
REQ-011 dbg_t100 / dbg_t50 / dbg_t10 / dbg_t1  output  1 each  raw toggle registers for the four tones.
REQ-012 dbg_temp_o_led  output  1  selected tone before enable gating.

Function
REQ-013 The block SHALL hold four independent 32-bit counters, one per tone, each paired with a 1-bit toggle register.
REQ-014 Each counter SHALL increment every cycle.
  - On the cycle it equals (cN-1), it SHALL return to 0 and invert its toggle register.
  - Each toggle therefore has a period of exactly 2*cN cycles at 50% duty.
REQ-015 Counters and toggles SHALL run continuously, independent of i_enable and of switch settings.
REQ-016 dbg_tN SHALL equal toggle register N directly, with no added latency.
REQ-017 dbg_temp_o_led SHALL be a combinational mux over {i_switch_1,i_switch_2}:
  - 00 -> t100
  - 01 -> t50
  - 10 -> t10
  - 11 -> t1
REQ-018 o_led_drive SHALL be the combinational AND of dbg_temp_o_led and i_enable.
REQ-019 A switch change SHALL take effect combinationally.
  - Tone phases SHALL NOT be disturbed by a switch change.
  - Glitches at the switch instant are permitted.
REQ-020 Every parameter SHALL be >= 1 and < 2^32.
  - cN = 1 SHALL toggle every cycle.

Reset
REQ-021 While i_reset = 1 at a rising edge, all counters SHALL load 0 and all toggles SHALL load 0.
  - Consequently all dbg_t* = 0 and o_led_drive = 0.
REQ-022 Reset SHALL take priority over counting at the same edge.
  - Reset mid-period SHALL discard partial counts.
REQ-023 After reset release, the first toggle of tone N SHALL occur at the cN-th rising edge.
  - The first edge with i_reset = 0 counts as edge 1.

Verification
Parameters for all scenarios: c100=10, c50=20, c10=50, c1=100.
REQ-024 Reset then release, switches=00, i_enable=1:
  - dbg_t100 rises after edge 10 and falls after edge 20.
  - o_led_drive tracks dbg_t100.
  - Period is 20 cycles.
REQ-025 Sweep switches 01/10/11 with i_enable=1:
  - dbg_temp_o_led periods are 40/100/200 cycles respectively.
  - Each tone is 50% duty.
REQ-026 i_enable=0 with any switch setting:
  - o_led_drive stays 0.
  - dbg_temp_o_led and all dbg_t* keep toggling.
REQ-027 Switch change mid-count (00 -> 11 at cycle 35):
  - Output immediately equals the current t1 value.
  - t100 phase is unaffected when re-selected.
REQ-028 Assert i_reset for 1 cycle at cycle 15:
  - All toggles are 0 on the next cycle.
  - dbg_t100 next rises 10 edges after release.
